// File: rtl/mult_pkg.sv
// Shared types and widths for the shared 4x4 multiplier front end.
package mult_pkg;

    localparam int unsigned OPW      = 4;
    localparam int unsigned PW       = 8;
    // Widest requester tag needed for up to 8 requesters.
    localparam int unsigned MAX_ID_W = 3;

    typedef struct packed {
        logic [OPW-1:0]      a;
        logic [OPW-1:0]      b;
        logic [MAX_ID_W-1:0] id;
    } mult_req_t;

    typedef struct packed {
        logic [PW-1:0]       product;
        logic [MAX_ID_W-1:0] id;
    } mult_rsp_t;

endpackage

// File: rtl/four_bit_multiplier.sv
// Unsigned 4x4 array multiplier, purely combinational.
module four_bit_multiplier
    import mult_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic [PW-1:0]  product_c
);

    // Sum of shifted partial products, one row per bit of b.
    always_comb begin
        product_c = '0;
        for (int i = 0; i < int'(OPW); i++) begin
            if (b[i]) begin
                product_c = product_c + (PW'(a) << i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set request searching upward from ptr+1, wrapping.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt
);

    logic [ID_W:0] sh;
    logic [N-1:0]  rot;
    logic [N-1:0]  rot_gnt;

    // Rotate so ptr+1 lands at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        sh      = {1'b0, ptr} + (ID_W + 1)'(1);
        rot     = N'({req, req} >> sh);
        rot_gnt = '0;
        for (int j = int'(N) - 1; j >= 0; j--) begin
            if (rot[j]) begin
                rot_gnt = N'(1) << j;
            end
        end
        gnt = N'(({rot_gnt, rot_gnt} << sh) >> N);
    end

endmodule

// File: rtl/shared_mult_arbiter.sv
// Round-robin front end sharing one 4x4 multiplier through a 2-stage pipe.
module shared_mult_arbiter
    import mult_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [OPW*NUM_REQ-1:0] req_a,
    input  logic [OPW*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [PW-1:0]          rsp_product,
    output logic                   busy
);

    logic                s1_valid;
    mult_req_t           s1_q;
    mult_rsp_t           s2_q;
    logic [ID_W-1:0]     ptr;

    logic                s2_load_c;
    logic                s1_load_c;
    logic [NUM_REQ-1:0]  arb_req_c;
    logic [NUM_REQ-1:0]  gnt_c;
    logic [ID_W-1:0]     gnt_id_c;
    mult_req_t           sel_c;
    logic                xfer_c;
    logic [PW-1:0]       product_c;

    assign s2_load_c = s1_valid && (!rsp_valid || rsp_ready);
    assign s1_load_c = !s1_valid || s2_load_c;
    assign arb_req_c = s1_load_c ? req_valid : '0;

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .req (arb_req_c),
        .ptr (ptr),
        .gnt (gnt_c)
    );

    // No acceptance while reset is held.
    assign req_ready = rst_n ? gnt_c : '0;
    assign xfer_c    = |req_ready;

    // Encode the grant and mux the winner's operands into an S1 payload.
    always_comb begin
        gnt_id_c = '0;
        sel_c    = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt_c[i]) begin
                gnt_id_c = ID_W'(i);
                sel_c.a  = req_a[OPW*i +: OPW];
                sel_c.b  = req_b[OPW*i +: OPW];
                sel_c.id = MAX_ID_W'(i);
            end
        end
    end

    four_bit_multiplier u_mult (
        .a         (s1_q.a),
        .b         (s1_q.b),
        .product_c (product_c)
    );

    // S1 operand register, S2 result register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_q      <= '0;
            rsp_valid <= 1'b0;
            s2_q      <= '0;
            ptr       <= ID_W'(NUM_REQ - 1);
        end else begin
            if (s1_load_c) begin
                s1_valid <= xfer_c;
                if (xfer_c) begin
                    s1_q <= sel_c;
                end
            end
            if (s2_load_c) begin
                rsp_valid    <= 1'b1;
                s2_q.product <= product_c;
                s2_q.id      <= s1_q.id;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (xfer_c) begin
                ptr <= gnt_id_c;
            end
        end
    end

    assign rsp_product = s2_q.product;
    assign rsp_id      = ID_W'(s2_q.id);
    assign busy        = s1_valid || rsp_valid;

endmodule
